// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage of the RV32 pipeline.
// Takes one load/store/ALU op per handshake from execute, checks alignment,
// issues a word-addressed request/ack transaction with byte strobes, and
// reports the completed op (rd, funct3, enables) to the writeback control.
// Load data is returned shifted down to byte lane 0, not extended.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ex_*                operation from execute; ex_ready is high in IDLE
//   mem_req/we/addr/wstrb/wdata, mem_ack/rdata   data-memory port
//   out_valid, d_out, alu_rd, f3_out, d_r_en, d_w_en, alu_reg_w_en
//                       completed-op results (single-cycle pulse)
//   misalign, bus_err   rejected-access and timeout pulses
module load_store_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_f3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_r,
  input  logic        ex_mem_w,
  input  logic        ex_reg_w_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] d_out,
  output logic [4:0]  alu_rd,
  output logic [2:0]  f3_out,
  output logic        d_r_en,
  output logic        d_w_en,
  output logic        alu_reg_w_en,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic {IDLE, REQ} state_t;

  // Timeout fires on the edge where the counter would step onto TIMEOUT,
  // so mem_req is high for exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Operation latched at acceptance, replayed on completion.
  logic       lat_ld;
  logic       lat_st;
  logic       lat_rwen;
  logic [4:0] lat_rd;
  logic [2:0] lat_f3;
  logic [1:0] lat_off;

  function automatic logic [3:0] wstrb_for(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   wstrb_for = 4'b0001 << off;
      2'b01:   wstrb_for = 4'b0011 << off;
      default: wstrb_for = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_for(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   wdata_for = {4{data[7:0]}};
      2'b01:   wdata_for = {2{data[15:0]}};
      default: wdata_for = data;
    endcase
  endfunction

  function automatic logic [31:0] lane0(input logic [31:0] data, input logic [1:0] off);
    lane0 = data >> {off, 3'b000};
  endfunction

  logic is_mem;
  logic illegal;

  always_comb begin
    is_mem  = ex_mem_r | ex_mem_w;
    // A simultaneous load+store request is treated as illegal as well.
    illegal = (ex_f3[1:0] == 2'b11)
            | (ex_f3[2] & ex_mem_w)
            | (ex_mem_r & ex_mem_w)
            | ((ex_f3[1:0] == 2'b01) & ex_addr[0])
            | ((ex_f3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00));
  end

  assign ex_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_ld       <= 1'b0;
      lat_st       <= 1'b0;
      lat_rwen     <= 1'b0;
      lat_rd       <= '0;
      lat_f3       <= '0;
      lat_off      <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wstrb    <= '0;
      mem_wdata    <= '0;
      out_valid    <= 1'b0;
      d_out        <= '0;
      alu_rd       <= '0;
      f3_out       <= '0;
      d_r_en       <= 1'b0;
      d_w_en       <= 1'b0;
      alu_reg_w_en <= 1'b0;
      misalign     <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      // Status outputs are pulses; data outputs hold between completions.
      out_valid    <= 1'b0;
      d_r_en       <= 1'b0;
      d_w_en       <= 1'b0;
      alu_reg_w_en <= 1'b0;
      misalign     <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              out_valid    <= 1'b1;
              alu_rd       <= ex_rd;
              f3_out       <= ex_f3;
              alu_reg_w_en <= ex_reg_w_en;
            end else if (illegal) begin
              out_valid <= 1'b1;
              misalign  <= 1'b1;
              alu_rd    <= ex_rd;
              f3_out    <= ex_f3;
            end else begin
              lat_ld    <= ex_mem_r;
              lat_st    <= ex_mem_w;
              lat_rwen  <= ex_reg_w_en;
              lat_rd    <= ex_rd;
              lat_f3    <= ex_f3;
              lat_off   <= ex_addr[1:0];
              mem_req   <= 1'b1;
              mem_we    <= ex_mem_w;
              mem_addr  <= {ex_addr[31:2], 2'b00};
              mem_wstrb <= ex_mem_w ? wstrb_for(ex_f3[1:0], ex_addr[1:0]) : 4'b0000;
              mem_wdata <= wdata_for(ex_f3[1:0], ex_wdata);
              cnt       <= '0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          // Ack is checked first so it wins over a same-cycle timeout.
          if (mem_ack) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_wstrb    <= 4'b0000;
            out_valid    <= 1'b1;
            d_out        <= lat_ld ? lane0(mem_rdata, lat_off) : 32'd0;
            d_r_en       <= lat_ld;
            d_w_en       <= lat_st;
            alu_reg_w_en <= lat_rwen;
            alu_rd       <= lat_rd;
            f3_out       <= lat_f3;
            state        <= IDLE;
          end else if (cnt == CNT_LAST) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            out_valid <= 1'b1;
            bus_err   <= 1'b1;
            alu_rd    <= lat_rd;
            f3_out    <= lat_f3;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed transactions, a behavioural model that
// predicts every output per cycle, and literal expectations per scenario.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_addr, ex_wdata;
  logic [2:0]  ex_f3;
  logic [4:0]  ex_rd;
  logic        ex_mem_r, ex_mem_w, ex_reg_w_en;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] d_out;
  logic [4:0]  alu_rd;
  logic [2:0]  f3_out;
  logic        d_r_en, d_w_en, alu_reg_w_en, misalign, bus_err;

  load_store_unit #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_f3(ex_f3), .ex_rd(ex_rd), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w),
    .ex_reg_w_en(ex_reg_w_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .d_out(d_out), .alu_rd(alu_rd), .f3_out(f3_out),
    .d_r_en(d_r_en), .d_w_en(d_w_en), .alu_reg_w_en(alu_reg_w_en),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_live = 0;
  bit          m_busy;
  int          m_wait;
  bit          p_ld, p_st, p_rwen;
  logic [4:0]  p_rd;
  logic [2:0]  p_f3;
  int          p_off;
  bit          e_valid, e_mis, e_be, e_r, e_w, e_rwen, e_req, e_we;
  logic [31:0] e_addr, e_wdata, e_dout;
  logic [3:0]  e_wstrb;
  logic [4:0]  e_rd;
  logic [2:0]  e_f3;

  function automatic bit legal(input logic [31:0] a, input logic [2:0] f3, input bit r, input bit w);
    int sz = int'(f3) % 4;
    if (sz == 3) return 0;
    if (w && f3 >= 3'd4) return 0;
    if (r && w) return 0;
    return (a % (32'd1 << sz)) == 0;
  endfunction

  function automatic logic [31:0] rep_data(input logic [2:0] f3, input logic [31:0] d);
    int sz = int'(f3) % 4;
    if (sz == 0) return (d & 32'hFF) * 32'h01010101;
    if (sz == 1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1; m_busy = 0; m_wait = 0;
      e_valid = 0; e_mis = 0; e_be = 0; e_r = 0; e_w = 0; e_rwen = 0;
      e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0;
      e_dout = 0; e_rd = 0; e_f3 = 0;
    end else if (m_live) begin
      e_valid = 0; e_mis = 0; e_be = 0; e_r = 0; e_w = 0; e_rwen = 0;
      if (!m_busy) begin
        if (ex_valid) begin
          if (!ex_mem_r && !ex_mem_w) begin
            e_valid = 1; e_rd = ex_rd; e_f3 = ex_f3; e_rwen = ex_reg_w_en;
          end else if (!legal(ex_addr, ex_f3, ex_mem_r, ex_mem_w)) begin
            e_valid = 1; e_mis = 1;
          end else begin
            m_busy = 1; m_wait = 0;
            p_ld = ex_mem_r; p_st = ex_mem_w; p_rwen = ex_reg_w_en;
            p_rd = ex_rd; p_f3 = ex_f3; p_off = int'(ex_addr % 4);
            e_req = 1; e_we = ex_mem_w;
            e_addr = ex_addr - (ex_addr % 4);
            e_wstrb = ex_mem_w ? 4'(((1 << (1 << (int'(ex_f3) % 4))) - 1) << p_off) : 4'd0;
            e_wdata = rep_data(ex_f3, ex_wdata);
          end
        end
      end else if (mem_ack) begin
        m_busy = 0; e_req = 0; e_valid = 1;
        e_r = p_ld; e_w = p_st; e_rwen = p_rwen; e_rd = p_rd; e_f3 = p_f3;
        e_dout = p_ld ? (mem_rdata >> (8 * p_off)) : 32'd0;
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          m_busy = 0; e_req = 0; e_valid = 1; e_be = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("misalign", 32'(misalign), 32'(e_mis));
      chk("bus_err", 32'(bus_err), 32'(e_be));
      chk("d_r_en", 32'(d_r_en), 32'(e_r));
      chk("d_w_en", 32'(d_w_en), 32'(e_w));
      chk("alu_reg_w_en", 32'(alu_reg_w_en), 32'(e_rwen));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("ex_ready", 32'(ex_ready), 32'(!m_busy));
      if (e_req) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_valid && !e_mis && !e_be) begin
        chk("alu_rd", 32'(alu_rd), 32'(e_rd));
        chk("f3_out", 32'(f3_out), 32'(e_f3));
      end
      if (e_valid && (e_r || e_w)) chk("d_out", d_out, e_dout);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                       input logic [4:0] rd, input bit r, input bit w, input bit rwen);
    ex_addr = a; ex_wdata = wd; ex_f3 = f3; ex_rd = rd;
    ex_mem_r = r; ex_mem_w = w; ex_reg_w_en = rwen; ex_valid = 1'b1;
    cycle();
    ex_valid = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rd);
    mem_ack = 1'b1; mem_rdata = rd;
    cycle();
    mem_ack = 1'b0;
  endtask

  int hi, be_seen;

  initial begin
    rst = 1'b1; ex_valid = 0; ex_addr = 0; ex_wdata = 0; ex_f3 = 0; ex_rd = 0;
    ex_mem_r = 0; ex_mem_w = 0; ex_reg_w_en = 0; mem_ack = 0; mem_rdata = 0;
    cycle(); cycle();
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst d_out", d_out, 32'd0);
    chk("rst ex_ready", 32'(ex_ready), 32'd1);
    rst = 1'b0;
    cycle();

    // LW 0x100, ack after 3 cycles
    issue(32'h100, 32'd0, 3'b010, 5'd3, 1, 0, 1);
    chk("lw mem_addr", mem_addr, 32'h100);
    chk("lw mem_we", 32'(mem_we), 32'd0);
    cycle(); cycle();
    ack(32'hDEADBEEF);
    chk("lw out_valid", 32'(out_valid), 32'd1);
    chk("lw d_out", d_out, 32'hDEADBEEF);
    chk("lw f3_out", 32'(f3_out), 32'd2);
    chk("lw d_r_en", 32'(d_r_en), 32'd1);
    cycle();

    // LB 0x103
    issue(32'h103, 32'd0, 3'b000, 5'd12, 1, 0, 1);
    cycle();
    ack(32'h80AABBCC);
    chk("lb d_out", d_out, 32'h00000080);
    chk("lb alu_rd", 32'(alu_rd), 32'd12);
    chk("lb f3_out", 32'(f3_out), 32'd0);
    cycle();

    // SH 0x202
    issue(32'h202, 32'h1234ABCD, 3'b001, 5'd0, 0, 1, 0);
    chk("sh mem_wstrb", 32'(mem_wstrb), 32'h0000000C);
    chk("sh mem_wdata", mem_wdata, 32'hABCDABCD);
    chk("sh mem_we", 32'(mem_we), 32'd1);
    chk("sh mem_addr", mem_addr, 32'h200);
    ack(32'h0);
    chk("sh d_w_en", 32'(d_w_en), 32'd1);
    chk("sh alu_reg_w_en", 32'(alu_reg_w_en), 32'd0);
    cycle();

    // Misaligned LW, then illegal SB with f3=100, then LH odd address
    issue(32'h101, 32'd0, 3'b010, 5'd4, 1, 0, 1);
    chk("mis lw misalign", 32'(misalign), 32'd1);
    chk("mis lw mem_req", 32'(mem_req), 32'd0);
    chk("mis lw ex_ready", 32'(ex_ready), 32'd1);
    chk("mis lw d_r_en", 32'(d_r_en), 32'd0);
    cycle();
    chk("mis pulse", 32'(misalign), 32'd0);
    issue(32'h104, 32'h55, 3'b100, 5'd0, 0, 1, 0);
    chk("mis sb100 misalign", 32'(misalign), 32'd1);
    issue(32'h301, 32'h0, 3'b101, 5'd9, 1, 0, 1);
    chk("mis lhu misalign", 32'(misalign), 32'd1);
    cycle();

    // SB lane 2, LHU upper half
    issue(32'h402, 32'hFFFFFF5A, 3'b000, 5'd0, 0, 1, 0);
    chk("sb mem_wstrb", 32'(mem_wstrb), 32'h4);
    chk("sb mem_wdata", mem_wdata, 32'h5A5A5A5A);
    ack(32'h0);
    issue(32'h502, 32'h0, 3'b101, 5'd21, 1, 0, 1);
    ack(32'hBEEF1234);
    chk("lhu d_out", d_out, 32'h0000BEEF);
    cycle();

    // Timeout: no ack
    issue(32'h600, 32'h0, 3'b010, 5'd5, 1, 0, 1);
    hi = 0; be_seen = 0;
    repeat (8) begin
      if (mem_req) hi++;
      if (bus_err) be_seen++;
      cycle();
    end
    chk("to req cycles", 32'(hi), 32'd4);
    chk("to bus_err pulses", 32'(be_seen), 32'd1);
    chk("to ex_ready", 32'(ex_ready), 32'd1);

    // Ack on the last timeout cycle wins
    issue(32'h700, 32'h0, 3'b010, 5'd6, 1, 0, 1);
    cycle(); cycle(); cycle();
    ack(32'h11223344);
    chk("late ack bus_err", 32'(bus_err), 32'd0);
    chk("late ack d_out", d_out, 32'h11223344);
    cycle();

    // Reset during REQ
    issue(32'h800, 32'h0, 3'b010, 5'd8, 1, 0, 1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst req mem_req", 32'(mem_req), 32'd0);
    chk("rst req out_valid", 32'(out_valid), 32'd0);
    chk("rst req d_out", d_out, 32'd0);
    cycle();
    chk("rst req no valid", 32'(out_valid), 32'd0);

    // SW then ALU op back to back
    issue(32'h900, 32'hCAFEF00D, 3'b010, 5'd0, 0, 1, 0);
    chk("sw mem_wstrb", 32'(mem_wstrb), 32'hF);
    mem_ack = 1'b1;
    ex_addr = 0; ex_f3 = 3'b000; ex_rd = 5'd7; ex_mem_r = 0; ex_mem_w = 0;
    ex_reg_w_en = 1; ex_valid = 1'b1;
    cycle();
    mem_ack = 1'b0;
    chk("sw out_valid", 32'(out_valid), 32'd1);
    chk("sw ex_ready", 32'(ex_ready), 32'd1);
    cycle();
    ex_valid = 1'b0;
    chk("alu out_valid", 32'(out_valid), 32'd1);
    chk("alu alu_rd", 32'(alu_rd), 32'd7);
    chk("alu d_w_en", 32'(d_w_en), 32'd0);
    chk("alu alu_reg_w_en", 32'(alu_reg_w_en), 32'd1);

    // Stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    cycle();
    chk("stray out_valid", 32'(out_valid), 32'd0);
    cycle();
    mem_ack = 1'b0;
    chk("stray out_valid2", 32'(out_valid), 32'd0);
    chk("stray alu_rd hold", 32'(alu_rd), 32'd7);
    cycle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
